// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared defaults, FSM states and port ids for ram_arbiter (RAM_ARB_FIXED_PRI_EN aware)
package ram_arb_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - 2-way winner select; RAM_ARB_FIXED_PRI_EN selects fixed priority
module ram_arb_pick
    import ram_arb_pkg::*;
(
`ifndef RAM_ARB_FIXED_PRI_EN
    input  logic       i_ptr,
`endif
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_win
);

    // winner select: a lone requester always wins, contention resolved by policy
    always_comb begin
        o_win = PORT_IF;
        o_gnt = 2'b00;
`ifdef RAM_ARB_FIXED_PRI_EN
        if (i_req[0]) o_win = PORT_IF;
        else          o_win = PORT_LS;
`else
        if (&i_req)        o_win = ~i_ptr;
        else if (i_req[0]) o_win = PORT_IF;
        else               o_win = PORT_LS;
`endif
        if (|i_req) o_gnt = o_win ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port access sequencer for the single-port RAM (RAM_ARB_FIXED_PRI_EN)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic              r_id;
    logic              r_we;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        w_pick_gnt;
    logic              w_win;
    logic              w_grant;

`ifndef RAM_ARB_FIXED_PRI_EN
    logic              r_ptr;
`endif

    ram_arb_pick u_pick (
`ifndef RAM_ARB_FIXED_PRI_EN
        .i_ptr (r_ptr),
`endif
        .i_req (req),
        .o_gnt (w_pick_gnt),
        .o_win (w_win)
    );

    assign w_grant   = (r_state == IDLE) && (|req);
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_rw    = r_rw;
    assign rdata     = r_rdata;

    // next state and state-decoded outputs
    always_comb begin
        w_next = r_state;
        gnt    = 2'b00;
        done   = 2'b00;
        busy   = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                gnt  = w_pick_gnt;
                if (|req) w_next = ACCESS;
            end
            ACCESS: w_next = DONE;
            DONE: begin
                done   = r_id ? 2'b10 : 2'b01;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // latch the winner's request so the RAM sees stable inputs for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= PORT_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_id    <= w_win;
            r_we    <= we[w_win];
            r_addr  <= w_win ? addr1 : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
        end
    end

    // RW strobe: registered, high only for the ACCESS cycle of a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rw <= 1'b0;
        else     r_rw <= w_grant & we[w_win];
    end

    // capture read data at the end of ACCESS; held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_rdata <= '0;
        else if ((r_state == ACCESS) && !r_we)  r_rdata <= ram_rdata;
    end

`ifndef RAM_ARB_FIXED_PRI_EN
    // last-winner pointer; reset to 1 so port 0 wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_ptr <= PORT_LS;
        else if (w_grant) r_ptr <= w_win;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (honours RAM_ARB_FIXED_PRI_EN)
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        busy;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rw;
    logic [31:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM macro stand-in: asynchronous read, write on rising edge while RW is high
    logic [31:0] env_mem [0:65535];
    assign ram_rdata = env_mem[ram_addr];
    always @(posedge clk) if (ram_rw) env_mem[ram_addr] <= ram_wdata;

    // reference state: expected memory contents, last winner, expected rdata register
    logic [31:0] model_mem [logic [15:0]];
    int          last_win;
    logic [31:0] exp_rdata;

    ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rw    (ram_rw),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int model_pick(input logic [1:0] r);
`ifdef RAM_ARB_FIXED_PRI_EN
        return r[0] ? 0 : 1;
`else
        if (r == 2'b11) return 1 - last_win;
        return r[0] ? 0 : 1;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    task automatic model_reset();
        last_win  = 1;
        exp_rdata = 32'h0;
    endtask

    // single-port access: gnt at T, access at T+1, done at T+2
    task automatic do_access(input int port, input logic w, input logic [15:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        if (port == 1) begin addr1 = a; wdata1 = d; we[1] = w; req[1] = 1'b1; end
        else           begin addr0 = a; wdata0 = d; we[0] = w; req[0] = 1'b1; end
        #1;
        n = 0;
        while (gnt == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        chk("gnt_wait", (n < 20), 1);
        chk("gnt", gnt, onehot(port));
        chk("idle_rw", ram_rw, 0);
        chk("idle_done", done, 0);
        last_win = port;
        @(negedge clk);
        req = 2'b00;
        addr0 = a ^ 16'h000C; addr1 = a ^ 16'h000C;
        wdata0 = ~d; wdata1 = ~d;
        #1;
        chk("acc_rw", ram_rw, w);
        chk("acc_addr", ram_addr, a);
        if (w) chk("acc_wdata", ram_wdata, d);
        chk("acc_gnt", gnt, 0);
        chk("acc_busy", busy, 1);
        if (w) model_mem[a] = d;
        else   exp_rdata = model_read(a);
        @(negedge clk); #1;
        chk("done", done, onehot(port));
        chk("done_rdata", rdata, exp_rdata);
        chk("done_rw", ram_rw, 0);
    endtask

    // reads under held or randomised request patterns, following the round-robin rule
    task automatic contend(input int k, input bit rnd);
        logic [1:0]  pat;
        logic [15:0] a;
        int          win;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            pat = rnd ? 2'($urandom_range(1, 3)) : 2'b11;
            req = pat; we = 2'b00;
            addr0 = 16'($urandom_range(0, 15)) & 16'hFFFE;
            addr1 = addr0 | 16'h0001;
            #1;
            win = model_pick(pat);
            chk("c_gnt", gnt, onehot(win));
            last_win = win;
            a = (win == 1) ? addr1 : addr0;
            @(negedge clk); #1;
            chk("c_acc_gnt", gnt, 0);
            chk("c_acc_addr", ram_addr, a);
            chk("c_acc_rw", ram_rw, 0);
            exp_rdata = model_read(a);
            @(negedge clk); #1;
            chk("c_done", done, onehot(win));
            chk("c_rdata", rdata, exp_rdata);
            chk("c_done_gnt", gnt, 0);
        end
        req = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) env_mem[i] = 32'h0;
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        model_reset();
        @(posedge clk); @(negedge clk); #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rw", ram_rw, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;

        // contention from reset: 0,1,0,1,... (fixed build: always 0)
        contend(6, 1'b0);

        // write then read on the load/store port
        do_access(1, 1'b1, 16'h0010, 32'hDEADBEEF);
        do_access(1, 1'b0, 16'h0010, 32'h0);
        chk("wr_rd_value", rdata, 32'hDEADBEEF);

        // field hold: addr0 moves 4 -> 8 after grant
        do_access(0, 1'b0, 16'h0004, 32'h0);

        // top-of-range address with neighbour 0
        do_access(0, 1'b1, 16'h0000, 32'h0BADF00D);
        do_access(1, 1'b1, 16'hFFFF, 32'hCAFEF00D);
        do_access(0, 1'b0, 16'hFFFF, 32'h0);
        chk("ffff_value", rdata, 32'hCAFEF00D);
        do_access(1, 1'b0, 16'h0000, 32'h0);
        chk("zero_value", rdata, 32'h0BADF00D);

        // random single-port traffic
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom_range(0, 15));
            if (ra[3]) ra = ra | 16'hFFF8;
            do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

        // random request patterns
        contend(20, 1'b1);

        // reset during the ACCESS cycle of a write
        @(negedge clk);
        req = 2'b10; we = 2'b10; addr1 = 16'h0020; wdata1 = 32'h12345678;
        #1;
        chk("mid_gnt", gnt, 2'b10);
        @(negedge clk); req = 2'b00; #1;
        chk("mid_rw_pre", ram_rw, 1);
        rst = 1'b1;
        #1;
        chk("mid_rw_rst", ram_rw, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_addr_rst", ram_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_no_done", done, 0);
        end
        contend(4, 1'b0);
        do_access(0, 1'b0, 16'h0020, 32'h0);
        chk("mid_aborted", rdata, model_read(16'h0020));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
